// File: rtl/knight_mtr_pkg.sv
// ============================================================================
// Module      : knight_mtr_pkg
// Description : Shared types, constants and speed-to-duty mapping for the
//               Knight motor PWM drive.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package knight_mtr_pkg;

    typedef logic signed [11:0] spd_t;

    localparam int unsigned PWM_BITS  = 11;
    localparam logic [10:0] DUTY_ZERO = 11'h400;

    // Half-scale offset plus half the signed speed; the 12-bit sum always lands in 0..2047.
    function automatic logic [10:0] spd2duty(input spd_t spd);
        spd_t        half;
        logic [11:0] sum;
        half = spd >>> 1;
        sum  = {1'b0, DUTY_ZERO} + half;
        return sum[10:0];
    endfunction

endpackage

`default_nettype wire

// File: rtl/pwm11_chnl.sv
// ============================================================================
// Module      : pwm11_chnl
// Description : One complementary PWM pair with dead time, driven from the
//               shared 11-bit period counter and an active duty value.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pwm11_chnl #(
    parameter int unsigned NONOVERLAP = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [10:0] cnt,
    input  logic [10:0] duty,
    output logic        pwm1,
    output logic        pwm2
);

    localparam logic [10:0] NOVL_11  = 11'(NONOVERLAP);
    localparam logic [11:0] NOVL_12  = 12'(NONOVERLAP);
    localparam logic [10:0] CNT_LAST = 11'h7FF;

    logic [11:0] pwm2_on;
    logic        pwm1_set;
    logic        pwm1_clr;
    logic        pwm2_set;
    logic        pwm2_clr;

    assign pwm2_on  = {1'b0, duty} + NOVL_12;
    assign pwm1_set = (cnt == NOVL_11) && (duty > NOVL_11);
    assign pwm1_clr = (cnt == duty);
    assign pwm2_set = ({1'b0, cnt} == pwm2_on) && (pwm2_on < {1'b0, CNT_LAST});
    assign pwm2_clr = (cnt == CNT_LAST);

    // Clear takes precedence so a coincident set/clear never produces a glitch pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm1 <= 1'b0;
            pwm2 <= 1'b0;
        end else begin
            if (pwm1_clr)
                pwm1 <= 1'b0;
            else if (pwm1_set)
                pwm1 <= 1'b1;

            if (pwm2_clr)
                pwm2 <= 1'b0;
            else if (pwm2_set)
                pwm2 <= 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/mtr_pwm_drv.sv
// ============================================================================
// Module      : mtr_pwm_drv
// Description : Left/right wheel PWM driver; double-buffers signed speed
//               commands and owns the shared 2048-clk period counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mtr_pwm_drv
    import knight_mtr_pkg::*;
#(
    parameter int unsigned NONOVERLAP = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [11:0] lft_spd,
    input  logic [11:0] rght_spd,
    input  logic        spd_vld,
    output logic        lftPWM1,
    output logic        lftPWM2,
    output logic        rghtPWM1,
    output logic        rghtPWM2,
    output logic        prd_strt
);

    localparam logic [PWM_BITS-1:0] CNT_LAST = '1;

    logic [PWM_BITS-1:0] cnt;
    spd_t                lft_shdw;
    spd_t                rght_shdw;
    logic [10:0]         lft_duty;
    logic [10:0]         rght_duty;
    logic                wrap_q;
    logic                prd_end;

    assign prd_end = (cnt == CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            lft_shdw  <= '0;
            rght_shdw <= '0;
            lft_duty  <= DUTY_ZERO;
            rght_duty <= DUTY_ZERO;
            wrap_q    <= 1'b0;
            prd_strt  <= 1'b0;
        end else begin
            cnt <= cnt + 1'b1;

            if (spd_vld) begin
                lft_shdw  <= lft_spd;
                rght_shdw <= rght_spd;
            end

            // A strobe landing on the last count bypasses the shadow so it is not lost for a period.
            if (prd_end) begin
                lft_duty  <= spd2duty(spd_vld ? lft_spd  : lft_shdw);
                rght_duty <= spd2duty(spd_vld ? rght_spd : rght_shdw);
            end

            // Two stages so the pulse lines up with the first registered PWM cycle of a period.
            wrap_q   <= prd_end;
            prd_strt <= wrap_q;
        end
    end

    pwm11_chnl #(
        .NONOVERLAP (NONOVERLAP)
    ) u_lft (
        .clk   (clk),
        .rst_n (rst_n),
        .cnt   (cnt),
        .duty  (lft_duty),
        .pwm1  (lftPWM1),
        .pwm2  (lftPWM2)
    );

    pwm11_chnl #(
        .NONOVERLAP (NONOVERLAP)
    ) u_rght (
        .clk   (clk),
        .rst_n (rst_n),
        .cnt   (cnt),
        .duty  (rght_duty),
        .pwm1  (rghtPWM1),
        .pwm2  (rghtPWM2)
    );

endmodule

`default_nettype wire

// File: tb/tb_mtr_pwm_drv.sv
// ============================================================================
// Module      : tb_mtr_pwm_drv
// Description : Directed self-checking bench for mtr_pwm_drv; measures PWM
//               high time per 2048-clk window aligned to prd_strt.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mtr_pwm_drv;

    localparam int NOVL = 32;

    logic        clk;
    logic        rst_n;
    logic [11:0] lft_spd;
    logic [11:0] rght_spd;
    logic        spd_vld;
    logic        lftPWM1;
    logic        lftPWM2;
    logic        rghtPWM1;
    logic        rghtPWM2;
    logic        prd_strt;

    int n_checks = 0;
    int n_pass   = 0;

    mtr_pwm_drv #(
        .NONOVERLAP (NOVL)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .lft_spd  (lft_spd),
        .rght_spd (rght_spd),
        .spd_vld  (spd_vld),
        .lftPWM1  (lftPWM1),
        .lftPWM2  (lftPWM2),
        .rghtPWM1 (rghtPWM1),
        .rghtPWM2 (rghtPWM2),
        .prd_strt (prd_strt)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Measures the next full window starting at prd_strt; optionally pulses spd_vld at window index pidx
    // (index i corresponds to the cycle in which the counter holds i+1).
    task automatic measure_window(input string tag, input int pidx,
                                  input logic [11:0] pl, input logic [11:0] pr,
                                  input int e_l1, input int e_l2, input int e_r1, input int e_r2);
        int k;
        int l1, l2, r1, r2, ovl, dtv, gl, gr;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!prd_strt && k < 4100);
        if (!prd_strt) begin
            n_checks++;
            $display("FAIL %s window_start: prd_strt not seen within %0d cycles", tag, k);
            return;
        end
        l1 = 0; l2 = 0; r1 = 0; r2 = 0; ovl = 0; dtv = 0; gl = 0; gr = 0;
        for (int idx = 0; idx < 2048; idx++) begin
            if (idx > 0) @(negedge clk);
            l1 += int'(lftPWM1);
            l2 += int'(lftPWM2);
            r1 += int'(rghtPWM1);
            r2 += int'(rghtPWM2);
            if ((lftPWM1 && lftPWM2) || (rghtPWM1 && rghtPWM2)) ovl++;
            if (!lftPWM1 && !lftPWM2) gl++;
            else begin
                if (gl > 0 && gl < NOVL) dtv++;
                gl = 0;
            end
            if (!rghtPWM1 && !rghtPWM2) gr++;
            else begin
                if (gr > 0 && gr < NOVL) dtv++;
                gr = 0;
            end
            if (idx == pidx) begin
                lft_spd  = pl;
                rght_spd = pr;
                spd_vld  = 1'b1;
            end else if (idx == pidx + 1) begin
                spd_vld  = 1'b0;
            end
        end
        n_checks++;
        if (l1 !== e_l1) $display("FAIL %s lftPWM1_high: got %0d expected %0d", tag, l1, e_l1);
        else n_pass++;
        n_checks++;
        if (l2 !== e_l2) $display("FAIL %s lftPWM2_high: got %0d expected %0d", tag, l2, e_l2);
        else n_pass++;
        n_checks++;
        if (r1 !== e_r1) $display("FAIL %s rghtPWM1_high: got %0d expected %0d", tag, r1, e_r1);
        else n_pass++;
        n_checks++;
        if (r2 !== e_r2) $display("FAIL %s rghtPWM2_high: got %0d expected %0d", tag, r2, e_r2);
        else n_pass++;
        n_checks++;
        if (ovl !== 0) $display("FAIL %s overlap_cycles: got %0d expected 0", tag, ovl);
        else n_pass++;
        n_checks++;
        if (dtv !== 0) $display("FAIL %s deadtime_violations: got %0d expected 0", tag, dtv);
        else n_pass++;
    endtask

    task automatic test_reset();
        int k;
        rst_n    = 1'b0;
        lft_spd  = 12'h000;
        rght_spd = 12'h000;
        spd_vld  = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({lftPWM1, lftPWM2, rghtPWM1, rghtPWM2, prd_strt} !== 5'b0)
            $display("FAIL reset_outputs: got %b expected 00000",
                     {lftPWM1, lftPWM2, rghtPWM1, rghtPWM2, prd_strt});
        else n_pass++;
        rst_n = 1'b1;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!prd_strt && k < 4200);
        n_checks++;
        if (k !== 2049) $display("FAIL reset_first_prd_strt: got cycle %0d expected 2049", k);
        else n_pass++;
        measure_window("idle", -1, 12'h000, 12'h000, 992, 991, 992, 991);
    endtask

    task automatic test_lft_max();
        measure_window("lft_max_cur", 10, 12'h7FF, 12'h000, 992, 991, 992, 991);
        measure_window("lft_max_nxt", -1, 12'h000, 12'h000, 2015, 0, 992, 991);
    endtask

    task automatic test_rght_min();
        measure_window("rght_min_cur", 10, 12'h7FF, 12'h800, 2015, 0, 992, 991);
        measure_window("rght_min_nxt", -1, 12'h000, 12'h000, 2015, 0, 0, 2015);
    endtask

    task automatic test_mid_period();
        measure_window("mid_cur", 999, 12'h200, 12'h200, 2015, 0, 0, 2015);
        measure_window("mid_nxt", -1, 12'h000, 12'h000, 1248, 735, 1248, 735);
    endtask

    task automatic test_back_to_back();
        measure_window("wrap_cur", 2046, 12'hE00, 12'hFFD, 1248, 735, 1248, 735);
        measure_window("wrap_nxt", -1, 12'h000, 12'h000, 736, 1247, 990, 993);
    endtask

    task automatic test_boundary();
        measure_window("bound_cur", 10, 12'h840, 12'h7BE, 736, 1247, 990, 993);
        measure_window("bound_nxt", -1, 12'h000, 12'h000, 0, 1983, 1983, 0);
    endtask

    task automatic test_reset_mid();
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!prd_strt && k < 4100);
        repeat (698) @(negedge clk);
        n_checks++;
        if (rghtPWM1 !== 1'b1) $display("FAIL rstmid_pwm1_high_before: got %b expected 1", rghtPWM1);
        else n_pass++;
        #1 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({lftPWM1, lftPWM2, rghtPWM1, rghtPWM2, prd_strt} !== 5'b0)
            $display("FAIL rstmid_async_clear: got %b expected 00000",
                     {lftPWM1, lftPWM2, rghtPWM1, rghtPWM2, prd_strt});
        else n_pass++;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!prd_strt && k < 4200);
        n_checks++;
        if (k !== 2049) $display("FAIL rstmid_first_prd_strt: got cycle %0d expected 2049", k);
        else n_pass++;
        measure_window("rstmid_resume", -1, 12'h000, 12'h000, 992, 991, 992, 991);
    endtask

    initial begin
        test_reset();
        test_lft_max();
        test_rght_min();
        test_mid_period();
        test_back_to_back();
        test_boundary();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
